pd_sequencer: RTL and testbench

- Shares one multiply/pattern-detect datapath between two requesters. The datapath computes C = A*B and raises a match flag when C equals the pattern.
- Grants requesters round-robin and issues one operand set per cycle to the datapath.
- Tracks requester IDs through the fixed datapath latency, returns each result tagged with its requester ID, and keeps a saturating match count per requester.
- Sits between the requester logic and the Pattern_detect datapath instance.

---
 rtl/pd_sequencer.sv | 169 ++++++++++++++++
 tb/tb_pd_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pd_sequencer.sv
`timescale 1ns/1ps
// Round-robin front end that shares one multiply/pattern-detect datapath between two requesters.
// A request accepted in cycle N returns its tagged result in N+LAT+2. Ready is a same-cycle grant; responses cannot be stalled.
module pd_sequencer #(
  parameter int A_W   = 11,
  parameter int B_W   = 11,
  parameter int P_W   = 21,
  parameter int LAT   = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [A_W-1:0]   req0_a,
  input  logic [B_W-1:0]   req0_b,
  input  logic [P_W-1:0]   req0_pattern,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [A_W-1:0]   req1_a,
  input  logic [B_W-1:0]   req1_b,
  input  logic [P_W-1:0]   req1_pattern,
  output logic             dp_issue,
  output logic [A_W-1:0]   dp_a,
  output logic [B_W-1:0]   dp_b,
  output logic [P_W-1:0]   dp_pattern,
  input  logic [P_W-1:0]   dp_c,
  input  logic             dp_match,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [P_W-1:0]   rsp_c,
  output logic             rsp_match,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] match_cnt0,
  output logic [CNT_W-1:0] match_cnt1
);

  logic             last_grant_q;
  logic             gnt0, gnt1, accept;

  logic             dp_issue_q;
  logic             issue_id_q;
  logic [A_W-1:0]   dp_a_q, dp_a_d;
  logic [B_W-1:0]   dp_b_q, dp_b_d;
  logic [P_W-1:0]   dp_pat_q, dp_pat_d;

  logic [LAT-1:0]   tag_v_q;
  logic [LAT-1:0]   tag_id_q;
  logic             tag_exit;

  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [P_W-1:0]   rsp_c_q;
  logic             rsp_match_q;

  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // With both requesting, the one not granted last wins; reset masks both grants.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0_valid && (!req1_valid || last_grant_q)) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign accept     = gnt0 | gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    dp_a_d   = gnt1 ? req1_a       : req0_a;
    dp_b_d   = gnt1 ? req1_b       : req0_b;
    dp_pat_d = gnt1 ? req1_pattern : req0_pattern;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      dp_issue_q   <= 1'b0;
      issue_id_q   <= 1'b0;
      dp_a_q       <= '0;
      dp_b_q       <= '0;
      dp_pat_q     <= '0;
    end else begin
      dp_issue_q <= accept;
      if (accept) begin
        last_grant_q <= gnt1;
        issue_id_q   <= gnt1;
        dp_a_q       <= dp_a_d;
        dp_b_q       <= dp_b_d;
        dp_pat_q     <= dp_pat_d;
      end
    end
  end

  // Tags travel alongside the datapath so each result leaves with its requester ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v_q  <= '0;
      tag_id_q <= '0;
    end else begin
      tag_v_q[0]  <= dp_issue_q;
      tag_id_q[0] <= issue_id_q;
      for (int i = 1; i < LAT; i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_id_q[i] <= tag_id_q[i-1];
      end
    end
  end

  assign tag_exit = tag_v_q[LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_c_q     <= '0;
      rsp_match_q <= 1'b0;
    end else begin
      rsp_valid_q <= tag_exit;
      if (tag_exit) begin
        rsp_id_q    <= tag_id_q[LAT-1];
        rsp_c_q     <= dp_c;
        rsp_match_q <= dp_match;
      end
    end
  end

  // Clear beats a same-cycle increment; counters stick at all-ones.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (clr_cnt) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else if (rsp_valid_q && rsp_match_q) begin
      if (!rsp_id_q && !(&cnt0_q)) cnt0_d = cnt0_q + CNT_W'(1);
      if (rsp_id_q && !(&cnt1_q))  cnt1_d = cnt1_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign dp_issue   = dp_issue_q;
  assign dp_a       = dp_a_q;
  assign dp_b       = dp_b_q;
  assign dp_pattern = dp_pat_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_c      = rsp_c_q;
  assign rsp_match  = rsp_match_q;
  assign match_cnt0 = cnt0_q;
  assign match_cnt1 = cnt1_q;

endmodule

// File: tb/tb_pd_sequencer.sv
`timescale 1ns/1ps
// Directed bench for pd_sequencer with a behavioural multiply/pattern datapath and a response scoreboard.
module tb_pd_sequencer;

  localparam int A_W   = 11;
  localparam int B_W   = 11;
  localparam int P_W   = 21;
  localparam int LAT   = 3;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [A_W-1:0]   req0_a, req1_a, dp_a;
  logic [B_W-1:0]   req0_b, req1_b, dp_b;
  logic [P_W-1:0]   req0_pattern, req1_pattern, dp_pattern, dp_c, rsp_c;
  logic             dp_issue, dp_match, rsp_valid, rsp_id, rsp_match, clr_cnt;
  logic [CNT_W-1:0] match_cnt0, match_cnt1;

  pd_sequencer #(.A_W(A_W), .B_W(B_W), .P_W(P_W), .LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_pattern(req0_pattern),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_pattern(req1_pattern),
    .dp_issue(dp_issue), .dp_a(dp_a), .dp_b(dp_b), .dp_pattern(dp_pattern),
    .dp_c(dp_c), .dp_match(dp_match),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_c(rsp_c), .rsp_match(rsp_match),
    .clr_cnt(clr_cnt), .match_cnt0(match_cnt0), .match_cnt1(match_cnt1)
  );

  // Datapath model: registered product and compare, LAT stages deep.
  logic [A_W+B_W-1:0] prod;
  logic [P_W-1:0]     mc_q [LAT];
  logic               mm_q [LAT];
  assign prod = (A_W+B_W)'(dp_a) * (A_W+B_W)'(dp_b);
  always @(posedge clk) begin
    mc_q[0] <= prod[P_W-1:0];
    mm_q[0] <= (prod[P_W-1:0] == dp_pattern);
    for (int i = 1; i < LAT; i++) begin
      mc_q[i] <= mc_q[i-1];
      mm_q[i] <= mm_q[i-1];
    end
  end
  assign dp_c     = mc_q[LAT-1];
  assign dp_match = mm_q[LAT-1];

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  typedef struct {
    logic v0; logic [A_W-1:0] a0; logic [B_W-1:0] b0; logic [P_W-1:0] p0;
    logic v1; logic [A_W-1:0] a1; logic [B_W-1:0] b1; logic [P_W-1:0] p1;
    logic r0; logic r1; logic clr; logic rst;
  } vec_t;

  typedef struct { int due; logic id; logic [P_W-1:0] c; logic m; } rsp_t;
  typedef struct { int due; logic [A_W-1:0] a; logic [B_W-1:0] b; logic [P_W-1:0] p; } iss_t;

  rsp_t rq[$];
  iss_t iq[$];

  function automatic vec_t mk(input int v0, a0, b0, p0, v1, a1, b1, p1, r0, r1,
                              input int clr = 0, input int rs = 0);
    vec_t v;
    v.v0 = (v0 != 0); v.a0 = A_W'(a0); v.b0 = B_W'(b0); v.p0 = P_W'(p0);
    v.v1 = (v1 != 0); v.a1 = A_W'(a1); v.b1 = B_W'(b1); v.p1 = P_W'(p1);
    v.r0 = (r0 != 0); v.r1 = (r1 != 0); v.clr = (clr != 0); v.rst = (rs != 0);
    return v;
  endfunction

  function automatic vec_t idle_v();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic push(input logic id, input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                      input logic [P_W-1:0] p);
    logic [A_W+B_W-1:0] full;
    rsp_t r;
    iss_t s;
    full = (A_W+B_W)'(a) * (A_W+B_W)'(b);
    s.due = cyc + 1; s.a = a; s.b = b; s.p = p;
    r.due = cyc + LAT + 2; r.id = id; r.c = full[P_W-1:0]; r.m = (full[P_W-1:0] == p);
    iq.push_back(s);
    rq.push_back(r);
  endtask

  // One clock cycle of stimulus; the expected grant decides what the scoreboard receives.
  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_pattern = v.p0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_pattern = v.p1;
    clr_cnt = v.clr; rst = v.rst;
    @(negedge clk);
    chk("req0_ready", 32'(req0_ready), 32'(v.r0));
    chk("req1_ready", 32'(req1_ready), 32'(v.r1));
    if (v.r0) push(1'b0, v.a0, v.b0, v.p0);
    if (v.r1) push(1'b1, v.a1, v.b1, v.p1);
  endtask

  // Cycle monitor: issue and response checks, held values, and counter expectations.
  logic           mon_en = 1'b0;
  logic [A_W-1:0] la = '0;
  logic [B_W-1:0] lb = '0;
  logic [P_W-1:0] lp = '0, lc = '0;
  logic           lm = 1'b0;
  int             ec0 = 0, ec1 = 0;
  logic           m_ei, m_er;
  iss_t           m_s;
  rsp_t           m_r;

  always @(negedge clk) begin
    if (mon_en) begin
      m_ei = 1'b0;
      if (iq.size() > 0 && iq[0].due == cyc) begin
        m_s = iq.pop_front();
        m_ei = 1'b1; la = m_s.a; lb = m_s.b; lp = m_s.p;
      end
      chk("dp_issue", 32'(dp_issue), 32'(m_ei));
      chk("dp_a", 32'(dp_a), 32'(la));
      chk("dp_b", 32'(dp_b), 32'(lb));
      chk("dp_pattern", 32'(dp_pattern), 32'(lp));
      m_er = 1'b0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        m_r = rq.pop_front();
        m_er = 1'b1; lc = m_r.c; lm = m_r.m;
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(m_er));
      if (m_er) chk("rsp_id", 32'(rsp_id), 32'(m_r.id));
      chk("rsp_c", 32'(rsp_c), 32'(lc));
      chk("rsp_match", 32'(rsp_match), 32'(lm));
      chk("match_cnt0", 32'(match_cnt0), 32'(ec0));
      chk("match_cnt1", 32'(match_cnt1), 32'(ec1));
      if (m_er && m_r.m) begin
        if (!m_r.id && ec0 < CMAX) ec0++;
        if (m_r.id && ec1 < CMAX)  ec1++;
      end
      if (clr_cnt || rst) begin
        ec0 = 0; ec1 = 0;
      end
      if (rst) begin
        rq.delete(); iq.delete();
        la = '0; lb = '0; lp = '0; lc = '0; lm = 1'b0;
      end
    end
  end

  localparam int NV = 12;
  vec_t tbl [NV];

  initial begin
    // Arbitration walk from reset (last_grant starts at 1), with mixed operands.
    tbl[0]  = mk(1,    3,    4,      12, 1, 5, 5,  7, 1, 0);
    tbl[1]  = mk(1,    3,    4,      12, 1, 5, 5,  7, 0, 1);
    tbl[2]  = mk(1,    3,    4,      12, 1, 5, 5,  7, 1, 0);
    tbl[3]  = mk(1,    3,    4,      12, 1, 5, 5,  7, 0, 1);
    tbl[4]  = mk(0,    0,    0,       0, 1, 7, 9, 63, 0, 1);
    tbl[5]  = mk(1, 2047, 2047, 2093057, 1, 1, 1,  1, 1, 0);
    tbl[6]  = mk(1,    2,    3,       6, 1, 1, 1,  1, 0, 1);
    tbl[7]  = mk(0,    0,    0,       0, 0, 0, 0,  0, 0, 0);
    tbl[8]  = mk(1,    0,    5,       0, 0, 0, 0,  0, 1, 0);
    tbl[9]  = mk(0,    0,    0,       0, 1, 4, 4, 16, 0, 1);
    tbl[10] = mk(1,    6,    6,      36, 1, 2, 2,  5, 1, 0);
    tbl[11] = mk(1,    6,    6,      36, 1, 2, 2,  5, 0, 1);

    rst = 1'b1; clr_cnt = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_pattern = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_pattern = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_dp_issue", 32'(dp_issue), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_rsp_c", 32'(rsp_c), 32'd0);
    chk("reset_dp_a", 32'(dp_a), 32'd0);
    chk("reset_cnt0", 32'(match_cnt0), 32'd0);

    for (int i = 0; i < NV; i++) apply(tbl[i]);
    repeat (8) apply(idle_v());

    // Single op: accept at N, response at N+5, counter at N+6.
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    apply(mk(1, 12, 2, 24, 0, 0, 0, 0, 1, 0));
    repeat (5) apply(idle_v());
    chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("single_rsp_id", 32'(rsp_id), 32'd0);
    chk("single_rsp_c", 32'(rsp_c), 32'd24);
    chk("single_rsp_match", 32'(rsp_match), 32'd1);
    apply(idle_v());
    chk("single_cnt0", 32'(match_cnt0), 32'd1);

    // Back-to-back requester 1, only k=4 matches.
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    for (int k = 1; k <= 8; k++) apply(mk(0, 0, 0, 0, 1, k, k, 16, 0, 1));
    repeat (8) apply(idle_v());
    chk("b2b_cnt1", 32'(match_cnt1), 32'd1);

    // Reset two cycles after three accepts drops everything in flight.
    for (int k = 0; k < 3; k++) apply(mk(1, 1, 1, 1, 0, 0, 0, 0, 1, 0));
    apply(idle_v());
    apply(mk(1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 1));
    repeat (8) apply(idle_v());
    chk("rstmid_cnt0", 32'(match_cnt0), 32'd0);
    chk("rstmid_cnt1", 32'(match_cnt1), 32'd0);
    apply(mk(1, 2, 2, 4, 1, 3, 3, 9, 1, 0));
    apply(mk(1, 2, 2, 4, 1, 3, 3, 9, 0, 1));
    repeat (8) apply(idle_v());

    // Saturation at all-ones, then clear against a coincident matching response.
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    repeat (5) apply(mk(1, 3, 3, 9, 0, 0, 0, 0, 1, 0));
    repeat (8) apply(idle_v());
    chk("sat_cnt0", 32'(match_cnt0), 32'd3);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    apply(mk(1, 3, 3, 9, 0, 0, 0, 0, 1, 0));
    apply(mk(1, 3, 3, 9, 0, 0, 0, 0, 1, 0));
    repeat (4) apply(idle_v());
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    chk("clr_coinc_rsp", 32'(rsp_valid), 32'd1);
    chk("clr_pre_cnt0", 32'(match_cnt0), 32'd1);
    apply(idle_v());
    chk("clr_win_cnt0", 32'(match_cnt0), 32'd0);

    repeat (8) apply(idle_v());
    chk("scoreboard_drained", 32'(rq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
